// File: rtl/audio_pkg.sv
// Shared types and constants for the codec audio capture path.
`default_nettype none

package audio_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    WAIT  = 2'd3
  } rx_state_t;

  localparam int   AUD_W        = 16;
  localparam logic I2S_LEFT_LVL = 1'b0;

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous pin followed by a single-edge detector.
`default_nettype none

module sync_edge_det #(
  parameter logic RISE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  // ff[1:0] is the synchroniser; ff[2] holds the previous synchronised value.
  logic [2:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[1:0], din};
    end
  end

  assign pulse = RISE ? (ff[1] & ~ff[2]) : (~ff[1] & ff[2]);

endmodule

`default_nettype wire

// File: rtl/i2s_adc_receiver.sv
// Deserialises codec ADC audio (codec is bus master) into {left,right} pairs
// delivered over a valid/ready handshake; all pins oversampled on Clk.
`default_nettype none

module i2s_adc_receiver
  import audio_pkg::*;
#(
  parameter int   DATA_W    = AUD_W,
  parameter int   LRC_DELAY = 1,
  parameter logic LEFT_LVL  = I2S_LEFT_LVL
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              AUD_BCLK,
  input  logic              AUD_ADCLRCK,
  input  logic              AUD_ADCDAT,
  output logic [2*DATA_W-1:0] ADCDATA,
  output logic              adc_valid,
  input  logic              adc_ready,
  output logic              adc_overrun,
  input  logic              overrun_clr,
  output logic              adc_frame_err
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int SKIP_W = (LRC_DELAY < 2) ? 1 : $clog2(LRC_DELAY + 1);

  logic              bclk_rise;
  logic [1:0]        lrck_ff;
  logic [1:0]        dat_ff;
  logic              lrck_s;
  logic              dat_s;

  rx_state_t         state;
  rx_state_t         state_d;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_base;
  logic [SKIP_W-1:0] skip_cnt;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] left_q;
  logic [DATA_W-1:0] word;
  logic              lrck_prev;
  logic              left_pend;

  logic              lrck_edge;
  logic              skip_done;
  logic              start_slot;
  logic              take_bit;
  logic              word_done;
  logic              frame_err_d;
  logic              is_left;
  logic              pair_done;
  logic              overrun_set;

  sync_edge_det #(.RISE(1'b1)) u_bclk_sync (
    .clk   (Clk),
    .rst_n (Reset_n),
    .din   (AUD_BCLK),
    .pulse (bclk_rise)
  );

  // LRCK and data share the BCLK synchroniser depth so they stay aligned with bclk_rise.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lrck_ff <= '0;
      dat_ff  <= '0;
    end else begin
      lrck_ff <= {lrck_ff[0], AUD_ADCLRCK};
      dat_ff  <= {dat_ff[0], AUD_ADCDAT};
    end
  end

  assign lrck_s    = lrck_ff[1];
  assign dat_s     = dat_ff[1];
  assign lrck_edge = bclk_rise && (lrck_s != lrck_prev);
  assign skip_done = (skip_cnt >= SKIP_W'(LRC_DELAY));
  assign is_left   = (lrck_s == LEFT_LVL);
  assign word      = {shift_q[DATA_W-2:0], dat_s};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= SYNC;
    end else begin
      state <= state_d;
    end
  end

  // The bclk_rise that reveals an LRCK edge counts as the first skipped edge.
  always_comb begin
    state_d     = state;
    start_slot  = 1'b0;
    take_bit    = 1'b0;
    word_done   = 1'b0;
    frame_err_d = 1'b0;
    bit_base    = bit_cnt;
    if (bclk_rise) begin
      if (lrck_edge) begin
        start_slot = 1'b1;
        bit_base   = '0;
        if (state == SHIFT) begin
          frame_err_d = 1'b1;
        end
        if (LRC_DELAY == 0) begin
          state_d  = SHIFT;
          take_bit = 1'b1;
        end else begin
          state_d  = SKIP;
        end
      end else begin
        case (state)
          SKIP: begin
            if (skip_done) begin
              state_d  = SHIFT;
              take_bit = 1'b1;
            end
          end
          SHIFT:   take_bit = 1'b1;
          default: ;
        endcase
      end
      if (take_bit && (bit_base == CNT_W'(DATA_W - 1))) begin
        word_done = 1'b1;
        state_d   = WAIT;
      end
    end
  end

  assign pair_done   = word_done && !is_left && left_pend;
  assign overrun_set = pair_done && adc_valid && !adc_ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bit_cnt   <= '0;
      skip_cnt  <= '0;
      shift_q   <= '0;
      left_q    <= '0;
      lrck_prev <= 1'b0;
      left_pend <= 1'b0;
    end else begin
      if (bclk_rise) begin
        lrck_prev <= lrck_s;
      end
      if (word_done) begin
        bit_cnt <= '0;
      end else if (take_bit) begin
        bit_cnt <= bit_base + CNT_W'(1);
      end else if (start_slot) begin
        bit_cnt <= '0;
      end
      if (start_slot) begin
        skip_cnt <= SKIP_W'(1);
      end else if (bclk_rise && (state == SKIP) && !skip_done) begin
        skip_cnt <= skip_cnt + SKIP_W'(1);
      end
      if (take_bit) begin
        shift_q <= word;
      end
      if (word_done && is_left) begin
        left_q <= word;
      end
      if (frame_err_d) begin
        left_pend <= 1'b0;
      end else if (word_done) begin
        left_pend <= is_left;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ADCDATA       <= '0;
      adc_valid     <= 1'b0;
      adc_overrun   <= 1'b0;
      adc_frame_err <= 1'b0;
    end else begin
      adc_frame_err <= frame_err_d;
      if (pair_done && !overrun_set) begin
        ADCDATA   <= {left_q, word};
        adc_valid <= 1'b1;
      end else if (!pair_done && adc_valid && adc_ready) begin
        adc_valid <= 1'b0;
      end
      if (overrun_set) begin
        adc_overrun <= 1'b1;
      end else if (overrun_clr) begin
        adc_overrun <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2s_adc_receiver.sv
// Bench for the codec capture path: slot-level codec BFM, event model and per-cycle compare.
`default_nettype none

module tb_i2s_adc_receiver;

  localparam int HALF = 4;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [1:0]  bclk = '0;
  logic [1:0]  lrck = '0;
  logic [1:0]  dat = '0;
  logic [1:0]  ready = 2'b11;
  logic [1:0]  ovclr = '0;
  logic [31:0] data_o [2];
  logic [1:0]  valid_o;
  logic [1:0]  ovr_o;
  logic [1:0]  ferr_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [1:0] rq = '0;
  logic [1:0] cq = '0;

  // Model: decisions per slot from the framing rules, timed from the BFM's BCLK rises.
  logic        m_lrck [2];
  logic        m_cap [2];
  logic        m_left [2];
  logic [15:0] m_lw [2];
  logic        m_inshift [2];
  logic        m_errpend [2];
  int          pair_due [2];
  logic [31:0] pair_dat [2];
  int          ferr_due [2];

  logic        ev [2];
  logic [31:0] ed [2];
  logic        eo [2];
  logic        ef [2];
  logic        pr, blk;
  logic [1:0]  vprev = '0;
  int          pair_cnt [2];
  int          pulse_len [2];
  int          ferr_cnt [2];
  logic [31:0] last_pair [2];

  always #10 Clk = ~Clk;

  i2s_adc_receiver dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .AUD_BCLK(bclk[0]), .AUD_ADCLRCK(lrck[0]), .AUD_ADCDAT(dat[0]),
    .ADCDATA(data_o[0]), .adc_valid(valid_o[0]), .adc_ready(ready[0]),
    .adc_overrun(ovr_o[0]), .overrun_clr(ovclr[0]), .adc_frame_err(ferr_o[0])
  );

  i2s_adc_receiver #(.DATA_W(16), .LRC_DELAY(0), .LEFT_LVL(1'b1)) dut_lj (
    .Clk(Clk), .Reset_n(Reset_n),
    .AUD_BCLK(bclk[1]), .AUD_ADCLRCK(lrck[1]), .AUD_ADCDAT(dat[1]),
    .ADCDATA(data_o[1]), .adc_valid(valid_o[1]), .adc_ready(ready[1]),
    .adc_overrun(ovr_o[1]), .overrun_clr(ovclr[1]), .adc_frame_err(ferr_o[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares < 40) $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_lrck[d] = 1'b0; m_cap[d] = 1'b0; m_left[d] = 1'b0; m_lw[d] = '0;
      m_inshift[d] = 1'b0; m_errpend[d] = 1'b0; pair_due[d] = -1; ferr_due[d] = -1;
    end
  endtask

  task automatic send_slot(input int d, input logic lvl, input logic [15:0] w, input int len);
    int   dl;
    int   idx;
    logic is_l;
    logic bitv;
    dl   = (d == 0) ? 1 : 0;
    is_l = (lvl == ((d == 0) ? 1'b0 : 1'b1));
    if (lvl != m_lrck[d]) begin
      m_errpend[d] = m_inshift[d];
      if (m_inshift[d]) m_left[d] = 1'b0;
      m_cap[d] = 1'b1;
    end else begin
      m_errpend[d] = 1'b0;
      m_cap[d] = 1'b0;
    end
    m_lrck[d] = lvl;
    m_inshift[d] = 1'b0;
    for (int p = 0; p < len; p++) begin
      idx  = p - dl;
      bitv = 1'b0;
      if (idx >= 0 && idx < 16) bitv = w[15-idx];
      @(negedge Clk);
      bclk[d] = 1'b0; lrck[d] = lvl; dat[d] = bitv;
      repeat (HALF) @(negedge Clk);
      bclk[d] = 1'b1;
      if (p == 0 && m_errpend[d]) begin
        ferr_due[d] = cyc + 3;
        m_errpend[d] = 1'b0;
      end
      if (m_cap[d] && idx == 15) begin
        if (is_l) begin
          m_left[d] = 1'b1; m_lw[d] = w;
        end else if (m_left[d]) begin
          pair_due[d] = cyc + 3; pair_dat[d] = {m_lw[d], w}; m_left[d] = 1'b0;
        end
      end
      repeat (HALF - 1) @(negedge Clk);
    end
    m_inshift[d] = m_cap[d] && (len > dl) && ((len - dl) < 16);
  endtask

  task automatic send_frame(input int d, input logic [15:0] l, input logic [15:0] r);
    logic ll;
    ll = (d == 0) ? 1'b0 : 1'b1;
    send_slot(d, ll, l, 32);
    send_slot(d, ~ll, r, 32);
  endtask

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    rq  <= ready;
    cq  <= ovclr;
  end

  always @(negedge Clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!Reset_n) begin
        ev[d] = 1'b0; ed[d] = '0; eo[d] = 1'b0; ef[d] = 1'b0;
      end else begin
        pr  = (pair_due[d] == cyc);
        blk = pr && ev[d] && !rq[d];
        if (pr && !blk) begin
          ev[d] = 1'b1; ed[d] = pair_dat[d];
        end else if (!pr && ev[d] && rq[d]) begin
          ev[d] = 1'b0;
        end
        if (blk) eo[d] = 1'b1;
        else if (cq[d]) eo[d] = 1'b0;
        ef[d] = (ferr_due[d] == cyc);
      end
      chk($sformatf("valid[%0d]", d), {31'd0, valid_o[d]}, {31'd0, ev[d]});
      chk($sformatf("data[%0d]", d), data_o[d], ed[d]);
      chk($sformatf("overrun[%0d]", d), {31'd0, ovr_o[d]}, {31'd0, eo[d]});
      chk($sformatf("frame_err[%0d]", d), {31'd0, ferr_o[d]}, {31'd0, ef[d]});
      if (valid_o[d]) begin
        if (!vprev[d]) begin
          pair_cnt[d]++; pulse_len[d] = 1; last_pair[d] = data_o[d];
        end else begin
          pulse_len[d]++;
        end
      end
      if (ferr_o[d]) ferr_cnt[d]++;
      vprev[d] = valid_o[d];
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    for (int d = 0; d < 2; d++) begin
      pair_cnt[d] = 0; pulse_len[d] = 0; ferr_cnt[d] = 0; last_pair[d] = '0;
      ev[d] = 1'b0; ed[d] = '0; eo[d] = 1'b0; ef[d] = 1'b0;
    end
    repeat (4) @(posedge Clk);
    #1;
    chk("reset_data", data_o[0], 32'h0);
    chk("reset_valid", {31'd0, valid_o[0]}, 32'h0);
    chk("reset_ovr", {31'd0, ovr_o[0]}, 32'h0);
    chk("reset_ferr", {31'd0, ferr_o[0]}, 32'h0);
    @(posedge Clk); #3 Reset_n = 1'b1;

    // BCLK idle for 10 us
    repeat (500) @(negedge Clk);
    chk("idle_pairs", pair_cnt[0], 0);

    // first frame is partial after reset; second yields the pair
    send_frame(0, 16'hA5C3, 16'h1234);
    chk("partial_dropped", pair_cnt[0], 0);
    send_frame(0, 16'hA5C3, 16'h1234);
    chk("first_pair", last_pair[0], 32'hA5C31234);
    chk("first_pair_cnt", pair_cnt[0], 1);
    chk("valid_one_clk", pulse_len[0], 1);

    // consumer stalls across two frames
    @(negedge Clk) ready[0] = 1'b0;
    send_frame(0, 16'h0001, 16'h0002);
    send_frame(0, 16'h0003, 16'h0004);
    chk("stall_data", data_o[0], 32'h00010002);
    chk("stall_ovr", {31'd0, ovr_o[0]}, 32'h1);
    chk("stall_valid", {31'd0, valid_o[0]}, 32'h1);
    @(negedge Clk) ovclr[0] = 1'b1;
    @(negedge Clk) ovclr[0] = 1'b0;
    @(negedge Clk);
    chk("ovr_cleared", {31'd0, ovr_o[0]}, 32'h0);
    ready[0] = 1'b1;
    repeat (3) @(negedge Clk);
    chk("stall_released", {31'd0, valid_o[0]}, 32'h0);
    chk("stall_pair_cnt", pair_cnt[0], 2);

    // short left slot: 9 data bits then LRCK toggles
    send_slot(0, 1'b0, 16'hFF80, 10);
    send_slot(0, 1'b1, 16'h5555, 32);
    chk("short_ferr_cnt", ferr_cnt[0], 1);
    chk("short_no_pair", pair_cnt[0], 2);
    send_frame(0, 16'h7FFF, 16'h8000);
    chk("after_short_pair", last_pair[0], 32'h7FFF8000);
    chk("after_short_cnt", pair_cnt[0], 3);

    // reset in the middle of a left-slot shift
    fork
      send_frame(0, 16'h1111, 16'h2222);
      begin
        repeat (HALF * 2 * 9) @(posedge Clk);
        #3 Reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_data", data_o[0], 32'h0);
        chk("async_rst_valid", {31'd0, valid_o[0]}, 32'h0);
        repeat (3) @(posedge Clk);
        #3 Reset_n = 1'b1;
      end
    join
    chk("rst_frame_dropped", pair_cnt[0], 3);
    send_frame(0, 16'h3333, 16'h4444);
    chk("post_rst_pair", last_pair[0], 32'h33334444);
    chk("post_rst_cnt", pair_cnt[0], 4);

    // left-justified build, left on LRCK high
    send_frame(1, 16'hBEEF, 16'hCAFE);
    chk("lj_pair", last_pair[1], 32'hBEEFCAFE);
    chk("lj_cnt", pair_cnt[1], 1);
    chk("lj_no_ferr", ferr_cnt[1], 0);

    repeat (10) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
